// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared constants and FSM encoding for match_sequencer
package match_pkg;

  localparam int BMR_W  = 1536;
  localparam int NOTE_W = 16;
  localparam logic [2*NOTE_W-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_START,
    ST_RUN,
    ST_CAPT,
    ST_PUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/match_result_fifo.sv
// rtl/match_result_fifo.sv - result FIFO with valid/ready pop and a full flag
// A push while full is accepted only when a pop frees the slot in the same cycle.
module match_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop;
  logic             wr_en;

  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);
  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/match_sequencer.sv
// rtl/match_sequencer.sv - fetches region bitmaps, runs the match accelerator, queues {note,length}
// Optional finish watchdog enabled by defining MATCH_TIMEOUT_EN.
module match_sequencer
  import match_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int BEAT_W      = 64,
  parameter int CNT_W       = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [CNT_W-1:0]      cmd_count,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rvalid,
  input  logic [BEAT_W-1:0]     mem_rdata,
  output logic [BMR_W-1:0]      acc_bmr,
  output logic                  acc_start,
  input  logic                  acc_finish,
  input  logic [NOTE_W-1:0]     acc_note,
  input  logic [NOTE_W-1:0]     acc_length,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*NOTE_W-1:0]   res_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  localparam int BEATS   = BMR_W / BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);

  if ((BMR_W % BEAT_W) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("match_sequencer: BEAT_W must divide 1536 and TIMEOUT_CYC must be positive");
  end

  state_t               state;
  state_t               state_n;
  logic [ADDR_W-1:0]    base_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     region_q;
  logic [CNT_W-1:0]     region_inc;
  logic [BEAT_CW-1:0]   beat_q;
  logic [2*NOTE_W-1:0]  capt_q;
  logic                 cmd_fire;
  logic                 beat_fire;
  logic                 push_fire;
  logic                 fifo_full;
  logic                 timed_out;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign beat_fire  = (state == ST_WAIT) && mem_rvalid;
  assign region_inc = region_q + CNT_W'(1);
  // A full FIFO still takes the push when the consumer pops in the same cycle.
  assign push_fire  = (state == ST_PUSH) && (!fifo_full || (res_valid && res_ready));
  assign mem_addr   = base_q + ADDR_W'(32'(region_q) * BEATS) + ADDR_W'(beat_q);

`ifdef MATCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign timed_out   = (state == ST_RUN) && !acc_finish && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ST_START)    tmo_cnt <= '0;
      else if (state == ST_RUN) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (cmd_fire)       err_q <= 1'b0;
      else if (timed_out) err_q <= 1'b1;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    acc_start = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_n = (cmd_count == '0) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        mem_req = 1'b1;
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) state_n = (beat_q == LAST_BEAT) ? ST_START : ST_REQ;
      end
      ST_START: begin
        acc_start = 1'b1;
        state_n   = ST_RUN;
      end
      ST_RUN: begin
        if (acc_finish)     state_n = ST_CAPT;
        else if (timed_out) state_n = ST_PUSH;
      end
      ST_CAPT: state_n = ST_PUSH;
      ST_PUSH: begin
        if (push_fire) state_n = (region_inc == count_q) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      count_q  <= '0;
      region_q <= '0;
      beat_q   <= '0;
      acc_bmr  <= '0;
      capt_q   <= '0;
    end else begin
      if (cmd_fire) begin
        base_q   <= cmd_base;
        count_q  <= cmd_count;
        region_q <= '0;
        beat_q   <= '0;
      end
      if (beat_fire) begin
        acc_bmr[32'(beat_q)*BEAT_W +: BEAT_W] <= mem_rdata;
        if (beat_q != LAST_BEAT) beat_q <= beat_q + BEAT_CW'(1);
      end
      // The accelerator's length register settles one cycle after finish.
      if (state == ST_CAPT) capt_q <= {acc_note, acc_length};
      if (timed_out)        capt_q <= TIMEOUT_DATA;
      if (push_fire) begin
        region_q <= region_inc;
        beat_q   <= '0;
      end
    end
  end

  match_result_fifo #(
    .WIDTH (2*NOTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_fire),
    .push_data (capt_q),
    .valid     (res_valid),
    .ready     (res_ready),
    .data      (res_data),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_match_sequencer.sv
// tb/tb_match_sequencer.sv - randomized self-checking bench for match_sequencer
// Define MATCH_TIMEOUT_EN to also exercise the finish watchdog.
module tb_match_sequencer;
  import match_pkg::*;

  localparam int ADDR_W = 16, BEAT_W = 64, CNT_W = 8, FIFO_DEPTH = 8, TIMEOUT_CYC = 64;
  localparam int BEATS = BMR_W / BEAT_W;

  logic                clk;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_base;
  logic [CNT_W-1:0]    cmd_count;
  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_rvalid;
  logic [BEAT_W-1:0]   mem_rdata;
  logic [BMR_W-1:0]    acc_bmr;
  logic                acc_start;
  logic                acc_finish;
  logic [15:0]         acc_note;
  logic [15:0]         acc_length;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_data;
  logic                busy;
  logic                done;
  logic                err_timeout;

  match_sequencer #(
    .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_count(cmd_count),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .acc_bmr(acc_bmr), .acc_start(acc_start), .acc_finish(acc_finish),
    .acc_note(acc_note), .acc_length(acc_length),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [31:0]       res_q[$];
  logic [ADDR_W-1:0] m_base;
  int                m_region;
  bit                const_data, fixed_acc, acc_mute, spur_en;
  int                lat_min = 1, lat_max = 1, ready_mode = 1;
  int                req_cnt, start_cnt, done_cnt, pop_cnt;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [31:0]       last_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected by the model", name);
  endtask

  task automatic chk_bmr(input string name, input logic [BMR_W-1:0] act, input logic [BMR_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int i = 0; i < BEATS; i++)
        if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL %s: beat %0d got %0h expected %0h", name, i, act[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [15:0] a);
    if (const_data) return 64'hA5A5_A5A5_A5A5_A5A5;
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1357};
  endfunction

  function automatic logic [BMR_W-1:0] exp_bitmap(input int r);
    logic [BMR_W-1:0] bm;
    for (int b = 0; b < BEATS; b++) bm[b*64 +: 64] = mem_data(m_base + 16'(r*BEATS + b));
    return bm;
  endfunction

  function automatic logic [31:0] acc_fn(input logic [BMR_W-1:0] bm);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < BMR_W/16; i++) n ^= bm[i*16 +: 16];
    if (fixed_acc) return 32'h000C_0010;
    return {n, bm[1023:1008] ^ 16'h1234};
  endfunction

  // Environment: memory responder, accelerator, consumer and cycle checks, all at negedge.
  initial begin
    logic [BMR_W-1:0]  eb;
    logic [31:0]       acc_res;
    bit                pend, spur;
    int                mcd, acc_cd;
    logic [ADDR_W-1:0] pend_addr;
    pend = 0; spur = 0; mcd = 0; acc_cd = 0; acc_res = '0; pend_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_rvalid = 1'b0; acc_finish = 1'b0; pend = 0; spur = 0; acc_cd = 0;
        addr_q.delete(); res_q.delete();
      end else begin
        if (acc_finish) begin
          acc_finish = 1'b0;
          if (!spur) {acc_note, acc_length} = acc_res;
          spur = 0;
        end
        if (acc_cd > 0) begin
          acc_cd--;
          if (acc_cd == 0) begin
            acc_finish = 1'b1; acc_note = 16'hDEAD; acc_length = 16'hBEEF;
            chk_bmr("bmr_stable_at_finish", acc_bmr, exp_bitmap(m_region - 1));
          end
        end
        if (acc_start) begin
          start_cnt++;
          eb = exp_bitmap(m_region);
          chk_bmr("bmr_at_start", acc_bmr, eb);
          res_q.push_back(acc_mute ? TIMEOUT_DATA : acc_fn(eb));
          acc_res = acc_fn(acc_bmr);
          m_region++;
          if (!acc_mute) acc_cd = $urandom_range(5, 1);
        end
        mem_rvalid = 1'b0;
        if (pend) begin
          mcd--;
          if (mcd == 0) begin
            mem_rvalid = 1'b1; mem_rdata = mem_data(pend_addr); pend = 0;
          end
        end
        if (mem_req) begin
          if (pend) fail("second_outstanding_req");
          if (addr_q.size() == 0) fail("unexpected_mem_req");
          else chk("mem_addr", mem_addr, addr_q.pop_front());
          req_cnt++;
          if (req_cnt == 1) first_addr = mem_addr;
          last_addr = mem_addr;
          pend = 1; pend_addr = mem_addr; mcd = $urandom_range(lat_max, lat_min);
          if (spur_en && acc_cd == 0 && !acc_finish && $urandom_range(3, 0) == 0) begin
            acc_finish = 1'b1; spur = 1; acc_note = 16'hBAD0; acc_length = 16'hBAD1;
          end
        end
        if (done) begin
          done_cnt++;
          chk("all_addr_issued_at_done", addr_q.size(), 0);
          chk("busy_during_done", busy, 1);
        end
      end
      case (ready_mode)
        0:       res_ready = 1'b0;
        1:       res_ready = 1'b1;
        default: res_ready = 1'($urandom_range(1, 0));
      endcase
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) fail("unexpected_result");
        else chk("res_data", res_data, res_q.pop_front());
        pop_cnt++;
        last_pop = res_data;
      end
      if (!res_valid) chk("res_data_when_empty", res_data, 0);
    end
  end

  task automatic clear_counts();
    req_cnt = 0; start_cnt = 0; pop_cnt = 0;
  endtask

  task automatic send_cmd(input logic [15:0] b, input int c);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail("cmd_ready_timeout");
    m_base = b; m_region = 0;
    addr_q.delete();
    for (int r = 0; r < c; r++)
      for (int k = 0; k < BEATS; k++) addr_q.push_back(b + 16'(r*BEATS + k));
    cmd_valid = 1'b1; cmd_base = b; cmd_count = CNT_W'(c);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int t = 0;
    while (done_cnt == d0 && t < limit) begin @(negedge clk); #1; t++; end
    if (t >= limit) fail("done_timeout");
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((res_q.size() != 0 || res_valid) && t < limit) begin @(negedge clk); #1; t++; end
    if (t >= limit) fail("drain_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_acc_start"}, acc_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk_bmr({tag, "_acc_bmr"}, acc_bmr, '0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, cnt;
    logic [BMR_W-1:0] a5;
    logic [15:0] b;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_count = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; acc_finish = 1'b0; acc_note = '0; acc_length = '0;
    res_ready = 1'b0; done_cnt = 0; last_pop = '0; first_addr = '0; last_addr = '0;
    m_base = '0; m_region = 0;
    clear_counts();
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single region, constant data, fixed latency 3, known accelerator result.
    const_data = 1; fixed_acc = 1; acc_mute = 0; spur_en = 0;
    lat_min = 3; lat_max = 3; ready_mode = 1;
    clear_counts(); d0 = done_cnt;
    send_cmd(16'h0100, 1);
    wait_done(d0, 400);
    drain(50);
    a5 = {BEATS{64'hA5A5_A5A5_A5A5_A5A5}};
    chk("t1_req_count", req_cnt, 24);
    chk("t1_first_addr", first_addr, 16'h0100);
    chk("t1_last_addr", last_addr, 16'h0117);
    chk_bmr("t1_bitmap", acc_bmr, a5);
    chk("t1_start_count", start_cnt, 1);
    chk("t1_pop_count", pop_cnt, 1);
    chk("t1_result", last_pop, 32'h000C_0010);

    // Zero-count command: straight to done, no traffic.
    const_data = 0; fixed_acc = 0; lat_min = 1; lat_max = 4;
    clear_counts(); d0 = done_cnt;
    send_cmd(16'h2000, 0);
    #1;
    chk("t2_done_cycle_after_accept", done, 1);
    wait_done(d0, 10);
    repeat (3) @(negedge clk);
    #1;
    chk("t2_req_count", req_cnt, 0);
    chk("t2_start_count", start_cnt, 0);
    chk("t2_idle_after", busy, 0);

    // Back-pressure: FIFO fills at 8, ninth result stalls in PUSH.
    ready_mode = 0; spur_en = 1;
    clear_counts(); d0 = done_cnt;
    send_cmd(16'h3000, 10);
    begin
      int t = 0;
      while (start_cnt < 9 && t < 3000) begin @(negedge clk); #1; t++; end
      if (t >= 3000) fail("t3_start_wait_timeout");
    end
    repeat (40) @(negedge clk);
    #1;
    chk("t3_starts_while_stalled", start_cnt, 9);
    chk("t3_busy_while_stalled", busy, 1);
    chk("t3_res_valid_while_stalled", res_valid, 1);
    chk("t3_no_done_while_stalled", done_cnt, d0);
    chk("t3_no_pops_while_stalled", pop_cnt, 0);
    ready_mode = 1;
    wait_done(d0, 1000);
    drain(50);
    chk("t3_pop_count", pop_cnt, 10);

    // Reset during beat 12 of region 2, then restart.
    ready_mode = 2;
    clear_counts();
    send_cmd(16'h4000, 5);
    begin
      int t = 0;
      while (req_cnt < 2*BEATS + 13 && t < 3000) begin @(negedge clk); #1; t++; end
      if (t >= 3000) fail("t4_req_wait_timeout");
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t4_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_counts(); d0 = done_cnt;
    send_cmd(16'h4000, 2);
    wait_done(d0, 800);
    drain(100);
    chk("t4_restart_first_addr", first_addr, 16'h4000);
    chk("t4_restart_req_count", req_cnt, 48);
    chk("t4_restart_pop_count", pop_cnt, 2);

    // Random commands, including address wrap.
    for (int i = 0; i < 6; i++) begin
      b = (i == 0) ? 16'hFFF0 : 16'($urandom);
      cnt = (i == 0) ? 2 : $urandom_range(3, 1);
      clear_counts(); d0 = done_cnt;
      send_cmd(b, cnt);
      wait_done(d0, 400 * cnt + 100);
      drain(200);
      chk("rand_req_count", req_cnt, 24 * cnt);
      chk("rand_start_count", start_cnt, cnt);
      chk("rand_pop_count", pop_cnt, cnt);
    end

`ifdef MATCH_TIMEOUT_EN
    // Accelerator never finishes: two timeout results and a sticky error.
    acc_mute = 1; spur_en = 0; ready_mode = 1;
    clear_counts(); d0 = done_cnt;
    send_cmd(16'h5000, 2);
    wait_done(d0, 1500);
    drain(50);
    chk("t5_pop_count", pop_cnt, 2);
    chk("t5_last_result", last_pop, 32'hFFFF_FFFF);
    chk("t5_err_set", err_timeout, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_err_sticky", err_timeout, 1);
    acc_mute = 0;
    send_cmd(16'h5000, 0);
    #1;
    chk("t5_err_cleared_by_cmd", err_timeout, 0);
`else
    chk("err_timeout_tied_low", err_timeout, 0);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
